// File: rtl/au_bitscan.sv
// Set-bit scanner: accepts a word and emits one beat per set bit (index order set by MSB_FIRST).
// Optional popcount output enabled by defining AU_BITSCAN_COUNT_EN.
module au_bitscan #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 0,
    localparam int ZW = (WIDTH > 1) ? $clog2(WIDTH) : 1,
    localparam int CW = ($clog2(WIDTH + 1) > 1) ? $clog2(WIDTH + 1) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ZW-1:0]    z,
    output logic             out_last,
    output logic             out_empty
`ifdef AU_BITSCAN_COUNT_EN
    ,
    output logic [CW-1:0]    cnt
`endif
);

    if (WIDTH < 1) begin : g_width_check
        $fatal(1, "au_bitscan: WIDTH must be >= 1");
    end

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StZero
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] residue_q, residue_d;
    logic [WIDTH-1:0] sel_onehot;
    logic [WIDTH-1:0] residue_clr;
    logic [ZW-1:0]    z_sel;
    logic             one_left;
    logic             accept;

    assign in_ready = (state_q == StIdle) && !rst;
    assign accept   = in_valid && in_ready;

    // Priority pick: the last match in loop order wins, so loop direction sets scan order.
    always_comb begin
        z_sel      = '0;
        sel_onehot = '0;
        if (MSB_FIRST != 0) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (residue_q[i]) begin
                    z_sel         = ZW'(i);
                    sel_onehot    = '0;
                    sel_onehot[i] = 1'b1;
                end
            end
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (residue_q[i]) begin
                    z_sel         = ZW'(i);
                    sel_onehot    = '0;
                    sel_onehot[i] = 1'b1;
                end
            end
        end
    end

    assign residue_clr = residue_q & ~sel_onehot;
    assign one_left    = (residue_clr == '0);

    always_comb begin
        state_d   = state_q;
        residue_d = residue_q;
        out_valid = 1'b0;
        z         = '0;
        out_last  = 1'b0;
        out_empty = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    residue_d = a;
                    state_d   = (a != '0) ? StScan : StZero;
                end
            end
            StScan: begin
                out_valid = 1'b1;
                z         = z_sel;
                out_last  = one_left;
                if (out_ready) begin
                    residue_d = residue_clr;
                    if (one_left) begin
                        state_d = StIdle;
                    end
                end
            end
            StZero: begin
                out_valid = 1'b1;
                out_last  = 1'b1;
                out_empty = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            residue_q <= '0;
        end else begin
            state_q   <= state_d;
            residue_q <= residue_d;
        end
    end

`ifdef AU_BITSCAN_COUNT_EN
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] pop_a;

    always_comb begin
        pop_a = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pop_a = pop_a + CW'(a[i]);
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (accept) begin
            cnt_d = pop_a;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Held count is only meaningful while a beat is on the output.
    assign cnt = out_valid ? cnt_q : '0;
`endif

endmodule

// File: doc/au_bitscan.md
AU_BITSCAN -- requirements
Module: AU_bitscan

Interface
REQ-001 SHALL have parameter WIDTH, default 8, input word length (>= 1); illegal value SHALL print an error and $finish at simulation start.
REQ-002 SHALL have parameter MSB_FIRST, default 0; 0 = scan lowest set bit first, 1 = highest set bit first.
REQ-003 SHALL define ZW = max(ceil(log2(WIDTH)), 1) and CW = max(ceil(log2(WIDTH+1)), 1).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  input word offered.
REQ-007 in_ready  output  1  block can accept a word.
REQ-008 a  input  WIDTH  input word; any number of bits may be set.
REQ-009 out_valid  output  1  index beat valid.
REQ-010 out_ready  input  1  downstream accepts beat.
REQ-011 z  output  ZW  binary index of the current set bit.
REQ-012 out_last  output  1  final beat of the current word.
REQ-013 out_empty  output  1  accepted word was all-zero.
REQ-014 cnt  output  CW  popcount of accepted word (present only with AU_BITSCAN_COUNT_EN).

Function
REQ-015 SHALL emit, per accepted word, one beat per set bit, giving each bit's index exactly once in scan order (ascending if MSB_FIRST=0, descending if 1).
REQ-016 SHALL implement states IDLE, SCAN, ZERO; in_ready SHALL be 1 exactly when state is IDLE and rst is 0.
REQ-017 IDLE: on in_valid && in_ready, SHALL register a into a residue mask and go to SCAN if a != 0, else to ZERO.
REQ-018 First beat SHALL be valid the cycle after acceptance (latency 1); no combinational path from a or in_valid to any output.
REQ-019 SCAN: out_valid=1; z = index of lowest (MSB_FIRST=0) or highest (MSB_FIRST=1) set residue bit; out_last=1 when residue has exactly one set bit; out_empty=0.
REQ-020 SCAN beat transfer (out_valid && out_ready) SHALL clear that residue bit; if out_last, SHALL go to IDLE, else stay in SCAN; exactly one beat per cycle maximum.
REQ-021 ZERO: SHALL emit one beat with out_valid=1, z=0, out_last=1, out_empty=1; on transfer, SHALL go to IDLE.
REQ-022 While out_valid=1 and out_ready=0, z, out_last, out_empty (and cnt) SHALL hold stable.
REQ-023 When out_valid=0, z, out_last, out_empty (and cnt) SHALL be 0.
REQ-024 No new word SHALL be accepted in the cycle its predecessor's last beat transfers; next acceptance is earliest one cycle later (IDLE).
REQ-025 WIDTH=1: z SHALL be 1 bit, constant 0; a=1 gives one beat with out_last=1, out_empty=0.
REQ-026 A word with all WIDTH bits set SHALL produce exactly WIDTH beats; index WIDTH-1 SHALL be representable in ZW bits.
REQ-027 Changes on a while not accepted SHALL have no effect.

Reset
REQ-028 On rst=1 at a clock edge, state SHALL become IDLE, residue 0, out_valid 0, z 0, out_last 0, out_empty 0 (cnt 0).
REQ-029 rst during SCAN or ZERO SHALL abandon the word; no further beats of it SHALL appear; in_ready SHALL be 1 in the first cycle with rst=0.
REQ-030 While rst=1, in_ready SHALL be 0 and no word SHALL be accepted.

Configuration
REQ-031 With macro AU_BITSCAN_COUNT_EN defined, port cnt SHALL exist, equal the popcount of the accepted word on every beat of that word (0 for a ZERO beat), obeying REQ-022/023.
REQ-032 Without AU_BITSCAN_COUNT_EN, port cnt and its popcount logic SHALL be absent; all other behaviour identical.

Verification
REQ-033 WIDTH=8, MSB_FIRST=0, a=8'b0010_0100, out_ready=1 -> beats z=2 (last=0), z=5 (last=1), then in_ready=1 next cycle; cnt=2 if enabled.
REQ-034 WIDTH=8, MSB_FIRST=1, a=8'hFF -> 8 beats z=7..0, out_last only on z=0.
REQ-035 WIDTH=8, a=8'h00 -> single beat z=0, out_empty=1, out_last=1, cnt=0.
REQ-036 WIDTH=8, a=8'h81, out_ready held 0 for 3 cycles -> z=0 stable 3 cycles, transfers on 4th, then z=7 last.
REQ-037 WIDTH=5, a=5'b10110, rst=1 asserted after first beat -> no further beats, outputs 0, in_ready=1 first cycle after rst released.
REQ-038 WIDTH=1, a=1 then a=0 back-to-back offered -> beat z=0 last, then (after IDLE cycle) beat out_empty=1.
